// File: rtl/bip_program_loader_if.sv
// Byte-stream input and program-memory write bus of the BIP program loader.
// The loader drives through the master modport; the UART/memory side uses slave.
interface bip_program_loader_if #(
  parameter int unsigned NB_ADDR  = 11,
  parameter int unsigned NB_BYTE  = 8,
  parameter int unsigned NB_INSTR = 16
);

  logic [NB_BYTE-1:0]  i_rx_data;
  logic                i_rx_done;
  logic                o_pm_wr_en;
  logic [NB_ADDR-1:0]  o_pm_addr;
  logic [NB_INSTR-1:0] o_pm_data;

  modport master (
    input  i_rx_data,
    input  i_rx_done,
    output o_pm_wr_en,
    output o_pm_addr,
    output o_pm_data
  );

  modport slave (
    output i_rx_data,
    output i_rx_done,
    input  o_pm_wr_en,
    input  o_pm_addr,
    input  o_pm_data
  );

endinterface

// File: rtl/bip_program_loader.sv
// Boots the BIP CPU: packs UART byte pairs into instruction words, writes them
// to program memory, then releases the CPU and reports when it halts.
module bip_program_loader #(
  parameter int unsigned NB_OPCODE   = 5,
  parameter int unsigned NB_OPERANDO = 11,
  parameter int unsigned NB_ADDR     = 11,
  parameter int unsigned NB_BYTE     = 8,
  parameter int unsigned NB_INSTR    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bip_program_loader_if.master bus,
  input  logic                 i_cpu_halt,
  input  logic                 i_restart,
  output logic                 o_cpu_rst,
  output logic                 o_cpu_en,
  output logic                 o_done,
  output logic                 o_overrun,
  output logic [NB_ADDR:0]     o_word_count
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  // The opcode occupies the top of the instruction, i.e. the top of the hi byte.
  if ((NB_INSTR != NB_OPCODE + NB_OPERANDO) || (NB_INSTR != 2 * NB_BYTE) ||
      (NB_OPCODE > NB_BYTE)) begin : g_bad_widths
    $error("bip_program_loader: inconsistent instruction field widths");
  end

  typedef enum logic [2:0] {
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_WRITE,
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e              state_q, state_d;
  logic [NB_BYTE-1:0]  hi_q, hi_d;
  logic [NB_ADDR-1:0]  addr_q, addr_d;
  logic [NB_ADDR:0]    count_q, count_d;
  logic                pm_wr_en_q, pm_wr_en_d;
  logic [NB_ADDR-1:0]  pm_addr_q, pm_addr_d;
  logic [NB_INSTR-1:0] pm_data_q, pm_data_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                cpu_en_q, cpu_en_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  logic                is_hlt_c;
  logic                restart_take_c;
  logic                rx_blocked_c;

  assign is_hlt_c       = (hi_q[NB_BYTE-1 -: NB_OPCODE] == '0);
  assign restart_take_c = (state_q == ST_HALTED) && i_restart;
  assign rx_blocked_c   = (state_q == ST_WRITE) || (state_q == ST_RUN) ||
                          (state_q == ST_HALTED);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_WAIT_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_HI: if (bus.i_rx_done) state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (bus.i_rx_done) state_d = ST_WRITE;
      ST_WRITE: begin
        if (is_hlt_c || (addr_q == LAST_ADDR)) state_d = ST_RUN;
        else                                   state_d = ST_WAIT_HI;
      end
      ST_RUN:     if (i_cpu_halt) state_d = ST_HALTED;
      ST_HALTED:  if (i_restart)  state_d = ST_WAIT_HI;
      default:    state_d = ST_WAIT_HI;
    endcase
  end

  // Datapath and output next values; outputs are decoded from the next state
  // so they line up with the state they belong to.
  always_comb begin
    hi_d       = hi_q;
    addr_d     = addr_q;
    count_d    = count_q;
    pm_addr_d  = pm_addr_q;
    pm_data_d  = pm_data_q;
    overrun_d  = overrun_q;
    pm_wr_en_d = (state_d == ST_WRITE);
    cpu_rst_d  = (state_d == ST_RUN) || (state_d == ST_HALTED);
    cpu_en_d   = (state_d == ST_RUN);
    done_d     = (state_d == ST_HALTED);

    if ((state_q == ST_WAIT_HI) && bus.i_rx_done) begin
      hi_d = bus.i_rx_data;
    end

    // The low byte of the write-data register doubles as the lo byte latch.
    if ((state_q == ST_WAIT_LO) && bus.i_rx_done) begin
      pm_addr_d = addr_q;
      pm_data_d = {hi_q, bus.i_rx_data};
      count_d   = count_q + (NB_ADDR+1)'(1);
    end

    if ((state_q == ST_WRITE) && (state_d == ST_WAIT_HI)) begin
      addr_d = addr_q + NB_ADDR'(1);
    end

    if (bus.i_rx_done && rx_blocked_c) begin
      overrun_d = 1'b1;
    end

    // Restart clears after the overrun set so a coincident byte ends cleared.
    if (restart_take_c) begin
      addr_d    = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      hi_q       <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      pm_wr_en_q <= 1'b0;
      pm_addr_q  <= '0;
      pm_data_q  <= '0;
      cpu_rst_q  <= 1'b0;
      cpu_en_q   <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      pm_wr_en_q <= pm_wr_en_d;
      pm_addr_q  <= pm_addr_d;
      pm_data_q  <= pm_data_d;
      cpu_rst_q  <= cpu_rst_d;
      cpu_en_q   <= cpu_en_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.o_pm_wr_en = pm_wr_en_q;
  assign bus.o_pm_addr  = pm_addr_q;
  assign bus.o_pm_data  = pm_data_q;
  assign o_cpu_rst      = cpu_rst_q;
  assign o_cpu_en       = cpu_en_q;
  assign o_done         = done_q;
  assign o_overrun      = overrun_q;
  assign o_word_count   = count_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// Directed bench for bip_program_loader with an 8-word program memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_bip_program_loader;

  localparam int unsigned NB_ADDR  = 3;
  localparam int unsigned NB_BYTE  = 8;
  localparam int unsigned NB_INSTR = 16;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_cpu_halt;
  logic             i_restart;
  logic             o_cpu_rst;
  logic             o_cpu_en;
  logic             o_done;
  logic             o_overrun;
  logic [NB_ADDR:0] o_word_count;

  int n_cmp = 0;
  int n_err = 0;

  bip_program_loader_if #(
    .NB_ADDR (NB_ADDR),
    .NB_BYTE (NB_BYTE),
    .NB_INSTR(NB_INSTR)
  ) bus ();

  bip_program_loader #(
    .NB_ADDR(NB_ADDR)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus.master),
    .i_cpu_halt  (i_cpu_halt),
    .i_restart   (i_restart),
    .o_cpu_rst   (o_cpu_rst),
    .o_cpu_en    (o_cpu_en),
    .o_done      (o_done),
    .o_overrun   (o_overrun),
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  // One instruction word; poke drives an extra byte during the WRITE cycle.
  task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo,
                           input logic [2:0] exp_addr, input logic [15:0] exp_data,
                           input logic [3:0] exp_cnt, input bit exp_run, input bit poke);
    send_byte(hi);
    check("wr_en_after_hi", 32'(bus.o_pm_wr_en), 0);
    send_byte(lo);
    check("wr_en_pulse", 32'(bus.o_pm_wr_en), 1);
    check("pm_addr", 32'(bus.o_pm_addr), 32'(exp_addr));
    check("pm_data", 32'(bus.o_pm_data), 32'(exp_data));
    check("word_count", 32'(o_word_count), 32'(exp_cnt));
    if (poke) begin
      bus.i_rx_data = 8'hFF;
      bus.i_rx_done = 1'b1;
    end
    tick();
    bus.i_rx_done = 1'b0;
    check("wr_en_end", 32'(bus.o_pm_wr_en), 0);
    check("cpu_en_after_write", 32'(o_cpu_en), 32'(exp_run));
    check("cpu_rst_after_write", 32'(o_cpu_rst), 32'(exp_run));
    if (poke) check("overrun_in_write", 32'(o_overrun), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst         = 1'b0;
    i_cpu_halt    = 1'b0;
    i_restart     = 1'b0;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    tick();
    tick();
    check("rst_wr_en", 32'(bus.o_pm_wr_en), 0);
    check("rst_pm_addr", 32'(bus.o_pm_addr), 0);
    check("rst_pm_data", 32'(bus.o_pm_data), 0);
    check("rst_cpu_rst", 32'(o_cpu_rst), 0);
    check("rst_cpu_en", 32'(o_cpu_en), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_overrun", 32'(o_overrun), 0);
    check("rst_count", 32'(o_word_count), 0);
    i_rst = 1'b1;
    tick();

    // Basic three-word program ending in HLT; stray controls while loading
    send_pair(8'h08, 8'h05, 3'd0, 16'h0805, 4'd1, 1'b0, 1'b0);
    i_restart  = 1'b1;
    i_cpu_halt = 1'b1;
    tick();
    i_restart  = 1'b0;
    i_cpu_halt = 1'b0;
    check("ignored_ctrl_count", 32'(o_word_count), 1);
    check("ignored_ctrl_done", 32'(o_done), 0);
    check("ignored_ctrl_cpu_rst", 32'(o_cpu_rst), 0);
    send_pair(8'h18, 8'h0A, 3'd1, 16'h180A, 4'd2, 1'b0, 1'b0);
    send_pair(8'h00, 8'h00, 3'd2, 16'h0000, 4'd3, 1'b1, 1'b0);
    check("run_overrun", 32'(o_overrun), 0);
    tick();
    check("run_hold_pm_addr", 32'(bus.o_pm_addr), 2);
    check("run_hold_cpu_en", 32'(o_cpu_en), 1);

    // Halt, repeated halt, byte in HALTED
    i_cpu_halt = 1'b1;
    tick();
    i_cpu_halt = 1'b0;
    check("halt_cpu_en", 32'(o_cpu_en), 0);
    check("halt_done", 32'(o_done), 1);
    check("halt_cpu_rst", 32'(o_cpu_rst), 1);
    i_cpu_halt = 1'b1;
    tick();
    i_cpu_halt = 1'b0;
    check("halt_again_done", 32'(o_done), 1);
    check("halt_again_cpu_en", 32'(o_cpu_en), 0);
    send_byte(8'h33);
    check("halted_rx_overrun", 32'(o_overrun), 1);
    check("halted_rx_wr_en", 32'(bus.o_pm_wr_en), 0);

    // Restart clears state; reload with an overrun in the WRITE cycle
    i_restart = 1'b1;
    tick();
    i_restart = 1'b0;
    check("restart_done", 32'(o_done), 0);
    check("restart_cpu_rst", 32'(o_cpu_rst), 0);
    check("restart_overrun", 32'(o_overrun), 0);
    check("restart_count", 32'(o_word_count), 0);
    send_pair(8'h08, 8'h05, 3'd0, 16'h0805, 4'd1, 1'b0, 1'b1);
    send_pair(8'h10, 8'h01, 3'd1, 16'h1001, 4'd2, 1'b0, 1'b0);
    check("overrun_sticky", 32'(o_overrun), 1);

    // Reset in the middle of a word
    send_byte(8'h08);
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    check("midrst_count", 32'(o_word_count), 0);
    check("midrst_overrun", 32'(o_overrun), 0);
    check("midrst_pm_addr", 32'(bus.o_pm_addr), 0);
    send_pair(8'h18, 8'h0A, 3'd0, 16'h180A, 4'd1, 1'b0, 1'b0);
    send_pair(8'h00, 8'h00, 3'd1, 16'h0000, 4'd2, 1'b1, 1'b0);

    // Restart coinciding with a received byte
    i_cpu_halt = 1'b1;
    tick();
    i_cpu_halt = 1'b0;
    check("halt2_done", 32'(o_done), 1);
    i_restart     = 1'b1;
    bus.i_rx_data = 8'h55;
    bus.i_rx_done = 1'b1;
    tick();
    i_restart     = 1'b0;
    bus.i_rx_done = 1'b0;
    check("restart_rx_overrun", 32'(o_overrun), 0);
    check("restart_rx_done", 32'(o_done), 0);
    check("restart_rx_count", 32'(o_word_count), 0);

    // Fill all eight words without HLT
    for (int i = 0; i < 8; i++) begin
      send_pair(8'h08, 8'(i + 1), 3'(i), 16'h0800 + 16'(i + 1), 4'(i + 1), (i == 7), 1'b0);
    end
    check("full_count", 32'(o_word_count), 8);
    check("full_overrun_before", 32'(o_overrun), 0);
    send_byte(8'h08);
    check("full_extra_overrun", 32'(o_overrun), 1);
    check("full_extra_wr_en_a", 32'(bus.o_pm_wr_en), 0);
    send_byte(8'h09);
    check("full_extra_wr_en_b", 32'(bus.o_pm_wr_en), 0);
    tick();
    check("full_extra_wr_en_c", 32'(bus.o_pm_wr_en), 0);
    check("full_hold_addr", 32'(bus.o_pm_addr), 7);
    check("full_hold_data", 32'(bus.o_pm_data), 32'h0808);
    check("full_hold_count", 32'(o_word_count), 8);
    check("full_cpu_en", 32'(o_cpu_en), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
